rtt_probe_meter: RTL and testbench
==================================

// Module: rtt_probe_meter
// PURPOSE
//  Inline stage on the RX data path, directly downstream of nf2_mac_grp (out_data/out_ctrl/out_wr/out_rdy).
//  Forwards every word unchanged with 1 cycle of latency.
//  Identifies RTT probe frames and computes RTT = RX timestamp (module header) - TX timestamp (payload).
//  Publishes last/min/max RTT and a probe count for the register block.
// PARAMETERS
//  DATA_WIDTH    64      data path width; only 64 is supported
//  CTRL_WIDTH    8       DATA_WIDTH/8
//  RX_TS_CTRL    8'hFD   ctrl value of the module header word that carries the 64-bit RX timestamp
//  PROBE_ETYPE   16'h88B5 ethertype that marks a probe frame
// PORTS
//  clk           in   1   core clock
//  reset         in   1   synchronous, active-high
//  in_data       in   64  data word from the MAC group
//  in_ctrl       in   8   ctrl word from the MAC group
//  in_wr         in   1   word valid
//  in_rdy        out  1   stage can accept a word
//  out_data      out  64  forwarded data word
//  out_ctrl      out  8   forwarded ctrl word
//  out_wr        out  1   forwarded word valid
//  out_rdy       in   1   downstream can accept a word
//  rtt_clear     in   1   1-cycle pulse: reset the statistics
//  rtt_last      out  64  most recent RTT, in clk ticks
//  rtt_min       out  64  minimum RTT since reset/clear
//  rtt_max       out  64  maximum RTT since reset/clear
//  rtt_valid     out  1   1-cycle pulse when a new RTT sample is committed
//  probe_cnt     out  32  count of probe frames measured
// BEHAVIOUR
//  Reset values
//   - out_wr, rtt_valid, rtt_last, rtt_max, probe_cnt = 0.
//   - rtt_min = all-ones.
//   - out_data, out_ctrl = 0; FSM goes to HDR.
//  Data path
//   - in_rdy = out_rdy, combinational.
//   - On each clk: out_wr<=in_wr; out_data<=in_data and out_ctrl<=in_ctrl when in_wr, otherwise hold.
//   - Downstream out_rdy follows the almost-full convention and accepts at least one word after deasserting it.
//   - Words are never dropped, reordered or modified.
//  Framing
//   - ctrl!=0 before the payload: module header word.
//   - ctrl==0: payload word.
//   - First ctrl!=0 after payload words: last word of the frame (EOP).
//   - Byte 0 of each word is data[63:56].
//  FSM (advances only on cycles with in_wr=1)
//   - HDR: a word with ctrl==RX_TS_CTRL latches rx_ts=data; any other ctrl!=0 word is ignored.
//     A ctrl==0 word is payload word 0 -> W1.
//     Clear ts_seen at entry to HDR; set it on the RX_TS_CTRL word.
//   - W1: is_probe = (data[31:16]==PROBE_ETYPE) && ts_seen.
//     ctrl!=0 (EOP) -> HDR, no sample; else -> W2.
//   - W2: tx_ts = data[63:0].
//     ctrl!=0 (EOP): the word is still valid, -> HDR with a sample if is_probe; else -> PAY.
//   - PAY: hold until an EOP word, then -> HDR with a sample if is_probe.
//  Sample commit (cycle after the EOP word is accepted)
//   - rtt = rx_ts - tx_ts, 64-bit modulo; a wrapped counter still yields the correct difference.
//   - Registered: rtt_last=rtt; rtt_min=min(rtt_min,rtt); rtt_max=max(rtt_max,rtt); probe_cnt+=1 (wraps at 2^32).
//   - rtt_valid pulses for exactly one cycle.
//   - The comparison is unsigned; rtt==rtt_min or rtt==rtt_max leaves that stat unchanged.
//   - A frame that ends before W2 (too short) produces no sample.
//  rtt_clear
//   - Sets rtt_min=all-ones, rtt_max=0, rtt_last=0, probe_cnt=0.
//   - Same cycle as a commit: clear first, then apply the sample (min=max=last=rtt, cnt=1).
//  Reset mid-frame: FSM -> HDR.
//   - The trailing words of that frame are treated as a frame with no RX_TS header, so no sample is taken.
//  Back-to-back frames: the next frame's header may arrive the cycle after EOP; no bubble is required.
// TESTING
//  1. Probe frame: rx_ts=1000, etype 88B5, tx_ts=400, 8 words -> out = in delayed 1 cycle; rtt_last=600, min=max=600, cnt=1, one rtt_valid.
//  2. Three probes with RTTs 600,200,900 -> min=200, max=900, last=900, cnt=3.
//  3. Wrap: rx_ts=5, tx_ts=64'hFFFF_FFFF_FFFF_FFFB -> rtt_last=10.
//  4. Non-probe frames: etype 0800, a frame with no RX_TS header, and a 2-word runt -> no rtt_valid; data forwarded intact.
//  5. out_rdy toggled randomly with a scoreboard -> in_rdy tracks out_rdy; zero word loss or reorder over 1000 frames.
//  6. rtt_clear on the same cycle as a commit of rtt=300 -> min=max=last=300, cnt=1.
//     reset mid-probe -> no sample; the next probe is measured normally.

Source files
------------

// File: rtl/rtt_probe_meter.sv
// Inline RX-path stage: forwards MAC words with one cycle of latency and measures
// probe-frame round-trip time (module-header RX timestamp minus payload TX timestamp).
module rtt_probe_meter #(
  parameter int              DATA_WIDTH  = 64,
  parameter int              CTRL_WIDTH  = DATA_WIDTH / 8,
  parameter logic [7:0]      RX_TS_CTRL  = 8'hFD,
  parameter logic [15:0]     PROBE_ETYPE = 16'h88B5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  rtt_clear,
  output logic [63:0]           rtt_last,
  output logic [63:0]           rtt_min,
  output logic [63:0]           rtt_max,
  output logic                  rtt_valid,
  output logic [31:0]           probe_cnt,
  output logic [1:0]            fsm_state
);

  // Handshake: a word transfers on every cycle in_wr=1. in_rdy is a pass-through of
  // the downstream almost-full style out_rdy, so a sender may still land one word after it drops.
  typedef enum logic [1:0] {HDR = 2'd0, W1 = 2'd1, W2 = 2'd2, PAY = 2'd3} state_t;

  state_t          state, state_nxt;
  logic [63:0]     rx_ts, rx_ts_nxt;
  logic [63:0]     tx_ts, tx_ts_nxt;
  logic [63:0]     sample_tx;
  logic [63:0]     rtt;
  logic            ts_seen, ts_seen_nxt;
  logic            is_probe, is_probe_nxt;
  logic            commit;
  logic            ctrl_nz;

  assign in_rdy    = out_rdy;
  assign fsm_state = state;
  assign ctrl_nz   = (in_ctrl != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= in_wr;
      if (in_wr) begin
        out_data <= in_data;
        out_ctrl <= in_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HDR;
      rx_ts    <= '0;
      tx_ts    <= '0;
      ts_seen  <= 1'b0;
      is_probe <= 1'b0;
    end else begin
      state    <= state_nxt;
      rx_ts    <= rx_ts_nxt;
      tx_ts    <= tx_ts_nxt;
      ts_seen  <= ts_seen_nxt;
      is_probe <= is_probe_nxt;
    end
  end

  // When the EOP lands in W2 the TX timestamp is the EOP word itself, so bypass the register.
  always_comb begin
    state_nxt    = state;
    rx_ts_nxt    = rx_ts;
    tx_ts_nxt    = tx_ts;
    ts_seen_nxt  = ts_seen;
    is_probe_nxt = is_probe;
    sample_tx    = tx_ts;
    commit       = 1'b0;
    if (in_wr) begin
      case (state)
        HDR: begin
          if (in_ctrl == RX_TS_CTRL) begin
            rx_ts_nxt   = in_data;
            ts_seen_nxt = 1'b1;
          end else if (!ctrl_nz) begin
            state_nxt = W1;
          end
        end
        W1: begin
          if (ctrl_nz) begin
            state_nxt   = HDR;
            ts_seen_nxt = 1'b0;
          end else begin
            is_probe_nxt = (in_data[31:16] == PROBE_ETYPE) && ts_seen;
            state_nxt    = W2;
          end
        end
        W2: begin
          tx_ts_nxt = in_data;
          sample_tx = in_data;
          if (ctrl_nz) begin
            state_nxt   = HDR;
            ts_seen_nxt = 1'b0;
            commit      = is_probe;
          end else begin
            state_nxt = PAY;
          end
        end
        PAY: begin
          if (ctrl_nz) begin
            state_nxt   = HDR;
            ts_seen_nxt = 1'b0;
            commit      = is_probe;
          end
        end
        default: state_nxt = HDR;
      endcase
    end
  end

  assign rtt = rx_ts - sample_tx;

  // A clear coinciding with a commit restarts the statistics from that sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      rtt_valid <= 1'b0;
      rtt_last  <= '0;
      rtt_min   <= '1;
      rtt_max   <= '0;
      probe_cnt <= '0;
    end else begin
      rtt_valid <= commit;
      if (commit) begin
        rtt_last  <= rtt;
        rtt_min   <= (rtt_clear || rtt < rtt_min) ? rtt : rtt_min;
        rtt_max   <= (rtt_clear || rtt > rtt_max) ? rtt : rtt_max;
        probe_cnt <= rtt_clear ? 32'd1 : probe_cnt + 32'd1;
      end else if (rtt_clear) begin
        rtt_last  <= '0;
        rtt_min   <= '1;
        rtt_max   <= '0;
        probe_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rtt_probe_meter.sv
// Directed bench for rtt_probe_meter: forwarding scoreboard plus hand-computed RTT statistics.
module tb_rtt_probe_meter;

  localparam logic [7:0]  RX_TS_CTRL = 8'hFD;
  localparam logic [15:0] ETYPE_PRB  = 16'h88B5;
  localparam logic [15:0] ETYPE_IP   = 16'h0800;
  localparam logic [63:0] ALL_ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        rtt_clear = 1'b0;
  logic [63:0] rtt_last, rtt_min, rtt_max;
  logic        rtt_valid;
  logic [31:0] probe_cnt;
  logic [1:0]  fsm_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          valid_cnt = 0;
  bit          mon_en = 1'b0;
  bit          rand_rdy = 1'b0;
  logic        in_wr_q = 1'b0;
  logic [71:0] exp_q[$];

  rtt_probe_meter dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .rtt_clear(rtt_clear), .rtt_last(rtt_last), .rtt_min(rtt_min), .rtt_max(rtt_max),
    .rtt_valid(rtt_valid), .probe_cnt(probe_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) in_wr_q <= reset ? 1'b0 : in_wr;

  // scoreboard: output words must equal the accepted input words, one cycle later, in order
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (out_wr !== in_wr_q) begin
        n_fail++;
        $display("FAIL out_wr_latency: got %b expected %b at %0t", out_wr, in_wr_q, $time);
      end
      if (out_wr === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL fwd_word: got %h/%h expected no word", out_data, out_ctrl);
        end else begin
          logic [71:0] exp_w;
          exp_w = exp_q.pop_front();
          if ({out_data, out_ctrl} !== exp_w) begin
            n_fail++;
            $display("FAIL fwd_word: got %h/%h expected %h/%h", out_data, out_ctrl,
                     exp_w[71:8], exp_w[7:0]);
          end
        end
      end
      if (rtt_valid === 1'b1) valid_cnt++;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] c, input bit clr);
    int guard = 0;
    if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
    #1;
    n_checks++;
    if (in_rdy !== out_rdy) begin
      n_fail++;
      $display("FAIL in_rdy_track: got %b expected %b", in_rdy, out_rdy);
    end
    while (in_rdy !== 1'b1 && guard < 1000) begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      guard++;
    end
    if (guard >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_rdy_wait: got in_rdy=%b expected 1 within 1000 cycles", in_rdy);
    end
    in_data   = d;
    in_ctrl   = c;
    in_wr     = 1'b1;
    rtt_clear = clr;
    exp_q.push_back({d, c});
    @(posedge clk);
    #1;
    in_wr     = 1'b0;
    rtt_clear = 1'b0;
  endtask

  // n_pay payload words; word1 carries the ethertype, word2 the TX timestamp, last word is EOP
  task automatic send_frame(input logic [63:0] rx, input bit has_ts, input logic [15:0] etype,
                            input logic [63:0] tx, input int n_pay, input bit clr_eop);
    logic [63:0] d;
    if (has_ts) send_word(rx, RX_TS_CTRL, 1'b0);
    send_word({48'h0, 16'(n_pay * 8)}, 8'hFF, 1'b0);
    for (int i = 0; i < n_pay; i++) begin
      d = {$urandom, $urandom};
      if (i == 1) d[31:16] = etype;
      if (i == 2) d = tx;
      send_word(d, (i == n_pay - 1) ? 8'h01 : 8'h00, clr_eop && (i == n_pay - 1));
    end
  endtask

  task automatic pulse_clear();
    rtt_clear = 1'b1;
    @(posedge clk);
    #1;
    rtt_clear = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks += 8;
    if (out_wr !== 1'b0)    begin n_fail++; $display("FAIL reset_out_wr: got %b expected 0", out_wr); end
    if (rtt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rtt_valid: got %b expected 0", rtt_valid); end
    if (rtt_last !== 64'd0) begin n_fail++; $display("FAIL reset_rtt_last: got %h expected 0", rtt_last); end
    if (rtt_max !== 64'd0)  begin n_fail++; $display("FAIL reset_rtt_max: got %h expected 0", rtt_max); end
    if (rtt_min !== ALL_ONES) begin n_fail++; $display("FAIL reset_rtt_min: got %h expected %h", rtt_min, ALL_ONES); end
    if (probe_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_probe_cnt: got %0d expected 0", probe_cnt); end
    if ({out_data, out_ctrl} !== 72'd0) begin n_fail++; $display("FAIL reset_out_word: got %h/%h expected 0", out_data, out_ctrl); end
    if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_fsm: got %0d expected 0", fsm_state); end
    mon_en = 1'b1;
  endtask

  task automatic test_probe();
    int v0 = valid_cnt;
    send_frame(64'd1000, 1'b1, ETYPE_PRB, 64'd400, 6, 1'b0);
    idle(3);
    n_checks += 5;
    if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL probe_valid_pulses: got %0d expected 1", valid_cnt - v0); end
    if (rtt_last !== 64'd600) begin n_fail++; $display("FAIL probe_last: got %0d expected 600", rtt_last); end
    if (rtt_min !== 64'd600)  begin n_fail++; $display("FAIL probe_min: got %0d expected 600", rtt_min); end
    if (rtt_max !== 64'd600)  begin n_fail++; $display("FAIL probe_max: got %0d expected 600", rtt_max); end
    if (probe_cnt !== 32'd1)  begin n_fail++; $display("FAIL probe_cnt: got %0d expected 1", probe_cnt); end
  endtask

  task automatic test_min_max();
    int v0;
    pulse_clear();
    n_checks += 4;
    if (rtt_min !== ALL_ONES) begin n_fail++; $display("FAIL clear_min: got %h expected %h", rtt_min, ALL_ONES); end
    if (rtt_max !== 64'd0)    begin n_fail++; $display("FAIL clear_max: got %h expected 0", rtt_max); end
    if (rtt_last !== 64'd0)   begin n_fail++; $display("FAIL clear_last: got %h expected 0", rtt_last); end
    if (probe_cnt !== 32'd0)  begin n_fail++; $display("FAIL clear_cnt: got %0d expected 0", probe_cnt); end
    v0 = valid_cnt;
    // back to back; the second frame ends on its TX timestamp word
    send_frame(64'd2000, 1'b1, ETYPE_PRB, 64'd1400, 5, 1'b0);
    send_frame(64'd3000, 1'b1, ETYPE_PRB, 64'd2800, 3, 1'b0);
    send_frame(64'd5000, 1'b1, ETYPE_PRB, 64'd4100, 4, 1'b0);
    idle(3);
    n_checks += 5;
    if (valid_cnt - v0 != 3) begin n_fail++; $display("FAIL mm_valid_pulses: got %0d expected 3", valid_cnt - v0); end
    if (rtt_last !== 64'd900) begin n_fail++; $display("FAIL mm_last: got %0d expected 900", rtt_last); end
    if (rtt_min !== 64'd200)  begin n_fail++; $display("FAIL mm_min: got %0d expected 200", rtt_min); end
    if (rtt_max !== 64'd900)  begin n_fail++; $display("FAIL mm_max: got %0d expected 900", rtt_max); end
    if (probe_cnt !== 32'd3)  begin n_fail++; $display("FAIL mm_cnt: got %0d expected 3", probe_cnt); end
  endtask

  task automatic test_wrap();
    send_frame(64'd5, 1'b1, ETYPE_PRB, 64'hFFFF_FFFF_FFFF_FFFB, 4, 1'b0);
    idle(3);
    n_checks += 4;
    if (rtt_last !== 64'd10)  begin n_fail++; $display("FAIL wrap_last: got %h expected 10", rtt_last); end
    if (rtt_min !== 64'd10)   begin n_fail++; $display("FAIL wrap_min: got %h expected 10", rtt_min); end
    if (rtt_max !== 64'd900)  begin n_fail++; $display("FAIL wrap_max: got %h expected 900", rtt_max); end
    if (probe_cnt !== 32'd4)  begin n_fail++; $display("FAIL wrap_cnt: got %0d expected 4", probe_cnt); end
  endtask

  task automatic test_non_probe();
    int v0 = valid_cnt;
    send_frame(64'd9000, 1'b1, ETYPE_IP,  64'd100, 5, 1'b0);
    send_frame(64'd9000, 1'b0, ETYPE_PRB, 64'd100, 5, 1'b0);
    send_frame(64'd9000, 1'b1, ETYPE_PRB, 64'd100, 2, 1'b0);
    idle(3);
    n_checks += 4;
    if (valid_cnt != v0)     begin n_fail++; $display("FAIL np_valid_pulses: got %0d expected 0", valid_cnt - v0); end
    if (probe_cnt !== 32'd4) begin n_fail++; $display("FAIL np_cnt: got %0d expected 4", probe_cnt); end
    if (rtt_last !== 64'd10) begin n_fail++; $display("FAIL np_last: got %0d expected 10", rtt_last); end
    if (exp_q.size() != 0)   begin n_fail++; $display("FAIL np_drain: got %0d words pending expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int          v0;
    int          n_pay;
    bit          has_ts;
    logic [15:0] et;
    logic [63:0] rx, tx, r;
    logic [63:0] e_last = 64'd0, e_min = ALL_ONES, e_max = 64'd0;
    logic [31:0] e_cnt = 32'd0;
    pulse_clear();
    v0 = valid_cnt;
    rand_rdy = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      has_ts = ($urandom_range(0, 3) != 0);
      et     = $urandom_range(0, 1) ? ETYPE_PRB : ETYPE_IP;
      n_pay  = $urandom_range(2, 6);
      rx     = {$urandom, $urandom};
      tx     = {$urandom, $urandom};
      send_frame(rx, has_ts, et, tx, n_pay, 1'b0);
      if (has_ts && et == ETYPE_PRB && n_pay >= 3) begin
        r      = rx - tx;
        e_last = r;
        if (r < e_min) e_min = r;
        if (r > e_max) e_max = r;
        e_cnt++;
      end
    end
    rand_rdy = 1'b0;
    out_rdy  = 1'b1;
    idle(3);
    n_checks += 6;
    if (valid_cnt - v0 != int'(e_cnt)) begin n_fail++; $display("FAIL b2b_valid_pulses: got %0d expected %0d", valid_cnt - v0, e_cnt); end
    if (probe_cnt !== e_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected %0d", probe_cnt, e_cnt); end
    if (rtt_last !== e_last) begin n_fail++; $display("FAIL b2b_last: got %h expected %h", rtt_last, e_last); end
    if (rtt_min !== e_min)   begin n_fail++; $display("FAIL b2b_min: got %h expected %h", rtt_min, e_min); end
    if (rtt_max !== e_max)   begin n_fail++; $display("FAIL b2b_max: got %h expected %h", rtt_max, e_max); end
    if (exp_q.size() != 0)   begin n_fail++; $display("FAIL b2b_drain: got %0d words pending expected 0", exp_q.size()); end
  endtask

  task automatic test_clear_commit();
    int v0 = valid_cnt;
    send_frame(64'd1300, 1'b1, ETYPE_PRB, 64'd1000, 4, 1'b1);
    idle(3);
    n_checks += 5;
    if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL cc_valid_pulses: got %0d expected 1", valid_cnt - v0); end
    if (rtt_last !== 64'd300) begin n_fail++; $display("FAIL cc_last: got %0d expected 300", rtt_last); end
    if (rtt_min !== 64'd300)  begin n_fail++; $display("FAIL cc_min: got %0d expected 300", rtt_min); end
    if (rtt_max !== 64'd300)  begin n_fail++; $display("FAIL cc_max: got %0d expected 300", rtt_max); end
    if (probe_cnt !== 32'd1)  begin n_fail++; $display("FAIL cc_cnt: got %0d expected 1", probe_cnt); end
  endtask

  task automatic test_reset_mid();
    int          v0;
    logic [63:0] d;
    send_word(64'd700, RX_TS_CTRL, 1'b0);
    send_word(64'd40, 8'hFF, 1'b0);
    send_word({$urandom, $urandom}, 8'h00, 1'b0);
    d = {$urandom, $urandom};
    d[31:16] = ETYPE_PRB;
    send_word(d, 8'h00, 1'b0);
    idle(1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    v0 = valid_cnt;
    d = 64'd500;
    d[31:16] = ETYPE_PRB;
    send_word(d, 8'h00, 1'b0);
    send_word(64'd200, 8'h00, 1'b0);
    send_word({$urandom, $urandom}, 8'h00, 1'b0);
    send_word({$urandom, $urandom}, 8'h01, 1'b0);
    idle(3);
    n_checks += 3;
    if (valid_cnt != v0)      begin n_fail++; $display("FAIL rm_valid_pulses: got %0d expected 0", valid_cnt - v0); end
    if (probe_cnt !== 32'd0)  begin n_fail++; $display("FAIL rm_cnt: got %0d expected 0", probe_cnt); end
    if (rtt_min !== ALL_ONES) begin n_fail++; $display("FAIL rm_min: got %h expected %h", rtt_min, ALL_ONES); end
    send_frame(64'd1700, 1'b1, ETYPE_PRB, 64'd1000, 5, 1'b0);
    idle(3);
    n_checks += 3;
    if (rtt_last !== 64'd700) begin n_fail++; $display("FAIL rm_next_last: got %0d expected 700", rtt_last); end
    if (probe_cnt !== 32'd1)  begin n_fail++; $display("FAIL rm_next_cnt: got %0d expected 1", probe_cnt); end
    if (valid_cnt - v0 != 1)  begin n_fail++; $display("FAIL rm_next_pulses: got %0d expected 1", valid_cnt - v0); end
  endtask

  initial begin
    test_reset();
    test_probe();
    test_min_max();
    test_wrap();
    test_non_probe();
    test_back_to_back();
    test_clear_commit();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: got %0d words pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
